// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a bimodal BHT of 2-bit saturating counters plus a direct-mapped BTB.
// Fetch side predicts taken/target for PCF combinationally. Execute side trains both tables on
// resolved conditional branches and flags a mispredict with the corrected next PC.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   PCF                         fetch PC
//   PredTakenF, PredTargetF     prediction for PCF (target = PCF+4 when not taken)
//   ValidE, BranchE, TakenE     E-stage valid, is-conditional-branch, resolved outcome
//   PCE, PCTargetE              E-stage PC and computed branch target
//   PredTakenE, PredTargetE     prediction that travelled with the E-stage instruction
//   MispredictE, RedirectPCE    redirect request and the correct next PC
//   BrCount, MissCount          performance counters, present only with BP_PERF_CNT_EN
//
// Build option: define BP_PERF_CNT_EN to add the BrCount/MissCount performance counters.
module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        ValidE,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
`endif
);

  localparam int unsigned Entries = 1 << IDX_W;

  logic [1:0]         bht_q     [Entries];
  logic [Entries-1:0] btb_v_q;
  logic [TAG_W-1:0]   btb_tag_q [Entries];
  logic [31:0]        btb_tgt_q [Entries];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f;
  logic             upd;
  logic [1:0]       bht_e, bht_next;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];
  assign upd   = ValidE && BranchE;

  // Fetch-side prediction reads the registered tables, so a same-cycle update to the same
  // index is seen only from the next cycle on.
  assign hit_f = btb_v_q[idx_f] && (btb_tag_q[idx_f] == tag_f);

  always_comb begin
    PredTakenF  = hit_f && bht_q[idx_f][1];
    PredTargetF = PredTakenF ? btb_tgt_q[idx_f] : PCF + 32'd4;
  end

  // A not-taken branch is correct whenever not-taken was predicted; the target only matters
  // when the branch is actually taken.
  always_comb begin
    MispredictE = upd && ((TakenE != PredTakenE) || (TakenE && (PredTargetE != PCTargetE)));
    RedirectPCE = TakenE ? PCTargetE : PCE + 32'd4;
  end

  // Saturating counter step.
  always_comb begin
    bht_e    = bht_q[idx_e];
    bht_next = bht_e;
    if (TakenE) begin
      if (bht_e != 2'b11) bht_next = bht_e + 2'd1;
    end else begin
      if (bht_e != 2'b00) bht_next = bht_e - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        bht_q[i] <= 2'b01;
      end
      btb_v_q <= '0;
    end else if (upd) begin
      bht_q[idx_e] <= bht_next;
      if (TakenE) btb_v_q[idx_e] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset: the valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (!reset && upd && TakenE) begin
      btb_tag_q[idx_e] <= tag_e;
      btb_tgt_q[idx_e] <= PCTargetE;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_count_q, miss_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      if (upd)         br_count_q   <= br_count_q + 32'd1;
      if (MispredictE) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign BrCount   = br_count_q;
  assign MissCount = miss_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a randomized run checked
// against a table-level behavioural model (integer counters, remembered branch PCs).
module tb_branch_predictor;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned N     = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PredTargetF, PCE, PCTargetE, PredTargetE, RedirectPCE;
  logic        PredTakenF, ValidE, BranchE, TakenE, PredTakenE, MispredictE;
`ifdef BP_PERF_CNT_EN
  logic [31:0] BrCount, MissCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counter strength 0..3 and the full PC of the last taken branch per slot.
  int          m_cnt [N];
  bit          m_v   [N];
  logic [31:0] m_pc  [N];
  logic [31:0] m_tgt [N];
  int unsigned m_br, m_miss;

  branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .ValidE      (ValidE),
    .BranchE     (BranchE),
    .TakenE      (TakenE),
    .PCE         (PCE),
    .PCTargetE   (PCTargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .MispredictE (MispredictE),
    .RedirectPCE (RedirectPCE)
`ifdef BP_PERF_CNT_EN
    ,
    .BrCount     (BrCount),
    .MissCount   (MissCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * N)) % (1 << TAG_W);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int unsigned i = idx_of(pc);
    return m_v[i] && (tag_of(m_pc[i]) == tag_of(pc)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    if (!(ValidE && BranchE)) return 1'b0;
    if (TakenE != PredTakenE) return 1'b1;
    return TakenE && (PredTargetE != PCTargetE);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 1;
      m_v[i]   = 1'b0;
    end
    m_br   = 0;
    m_miss = 0;
  endtask

  task automatic model_commit();
    int unsigned i;
    if (ValidE && BranchE) begin
      i = idx_of(PCE);
      m_br++;
      if (m_misp()) m_miss++;
      if (TakenE) begin
        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_v[i]   = 1'b1;
        m_pc[i]  = PCE;
        m_tgt[i] = PCTargetE;
      end else begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end
    end
  endtask

  task automatic drive_e(input logic v, input logic b, input logic t, input logic [31:0] pce,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ValidE = v; BranchE = b; TakenE = t; PCE = pce;
    PCTargetE = tgt; PredTakenE = pt; PredTargetE = ptgt;
  endtask

  task automatic idle_e();
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Commits the model for the coming edge (unless reset holds) and moves to edge+1.
  task automatic tick();
    if (!reset) model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_e();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_e();
    PCF = 32'h100;
    reset = 1'b1;
    model_reset();
    #2;
    n_tests++; if (PredTakenF !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred_taken: got %0b want 0", PredTakenF); end
    n_tests++; if (PredTargetF !== 32'h104) begin
      n_fail++; $display("FAIL reset_pred_target: got %0h want 104", PredTargetF); end
    n_tests++; if (MispredictE !== 1'b0) begin
      n_fail++; $display("FAIL reset_mispredict: got %0b want 0", MispredictE); end
    // E inputs still drive the combinational mispredict while reset is held.
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    #1;
    n_tests++; if (MispredictE !== 1'b1) begin
      n_fail++; $display("FAIL reset_e_mispredict: got %0b want 1", MispredictE); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_e();
    #2;
    n_tests++; if (PredTakenF !== 1'b0) begin
      n_fail++; $display("FAIL reset_discards_update: got %0b want 0", PredTakenF); end
`ifdef BP_PERF_CNT_EN
    n_tests++; if (BrCount !== 32'd0 || MissCount !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", BrCount, MissCount); end
`endif
  endtask

  // First taken branch mispredicts; same-cycle fetch sees old contents, next cycle sees new.
  task automatic test_same_cycle_train();
    do_reset();
    PCF = 32'h100;
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    #2;
    n_tests++; if (MispredictE !== 1'b1) begin
      n_fail++; $display("FAIL first_taken_misp: got %0b want 1", MispredictE); end
    n_tests++; if (RedirectPCE !== 32'h80) begin
      n_fail++; $display("FAIL first_taken_redirect: got %0h want 80", RedirectPCE); end
    n_tests++; if (PredTakenF !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_old: got %0b want 0", PredTakenF); end
    tick();
    idle_e();
    #2;
    n_tests++; if (PredTakenF !== 1'b1) begin
      n_fail++; $display("FAIL trained_taken: got %0b want 1", PredTakenF); end
    n_tests++; if (PredTargetF !== 32'h80) begin
      n_fail++; $display("FAIL trained_target: got %0h want 80", PredTargetF); end
  endtask

  task automatic test_hysteresis();
    PCF = 32'h100;
    for (int k = 0; k < 3; k++) begin
      drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
      #2;
      n_tests++; if (MispredictE !== 1'b0) begin
        n_fail++; $display("FAIL hyst_taken_%0d: got %0b want 0", k, MispredictE); end
      tick();
    end
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    #2;
    n_tests++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin
      n_fail++; $display("FAIL hyst_nt1_misp: got %0b/%0h want 1/104", MispredictE, RedirectPCE);
    end
    tick();
    idle_e();
    #2;
    n_tests++; if (PredTakenF !== 1'b1) begin
      n_fail++; $display("FAIL hyst_still_taken: got %0b want 1", PredTakenF); end
    drive_e(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    tick();
    idle_e();
    #2;
    n_tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin
      n_fail++; $display("FAIL hyst_now_nt: got %0b/%0h want 0/104", PredTakenF, PredTargetF);
    end
`ifdef BP_PERF_CNT_EN
    n_tests++; if (BrCount !== 32'd6) begin
      n_fail++; $display("FAIL perf_br: got %0d want 6", BrCount); end
    n_tests++; if (MissCount !== m_miss) begin
      n_fail++; $display("FAIL perf_miss: got %0d want %0d", MissCount, m_miss); end
    reset = 1'b1;
    #1;
    n_tests++; if (BrCount !== 32'd0 || MissCount !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", BrCount, MissCount); end
    reset = 1'b0;
`endif
  endtask

  task automatic test_alias();
    do_reset();
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    tick();
    idle_e();
    PCF = 32'h100 + (32'd4 << IDX_W);
    #2;
    n_tests++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h204) begin
      n_fail++; $display("FAIL alias_miss: got %0b/%0h want 0/204", PredTakenF, PredTargetF); end
    // Training the alias overwrites the shared entry.
    drive_e(1'b1, 1'b1, 1'b1, 32'h200, 32'h300, 1'b0, 32'h204);
    tick();
    idle_e();
    #2;
    n_tests++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin
      n_fail++; $display("FAIL alias_over: got %0b/%0h want 1/300", PredTakenF, PredTargetF); end
    PCF = 32'h100;
    #1;
    n_tests++; if (PredTakenF !== 1'b0) begin
      n_fail++; $display("FAIL alias_evicted: got %0b want 0", PredTakenF); end
  endtask

  task automatic test_target_and_gating();
    do_reset();
    PCF = 32'h100;
    drive_e(1'b1, 1'b1, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
    #2;
    n_tests++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h90) begin
      n_fail++; $display("FAIL tgt_mismatch: got %0b/%0h want 1/90", MispredictE, RedirectPCE); end
    ValidE = 1'b0;
    #1;
    n_tests++; if (MispredictE !== 1'b0) begin
      n_fail++; $display("FAIL invalid_no_misp: got %0b want 0", MispredictE); end
    tick();
    drive_e(1'b1, 1'b0, 1'b1, 32'h100, 32'h90, 1'b0, 32'h0);
    #1;
    n_tests++; if (MispredictE !== 1'b0) begin
      n_fail++; $display("FAIL nonbranch_no_misp: got %0b want 0", MispredictE); end
    tick();
    idle_e();
    #1;
    n_tests++; if (PredTakenF !== 1'b0) begin
      n_fail++; $display("FAIL gated_no_train: got %0b want 0", PredTakenF); end
    drive_e(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h40, 1'b0, 32'h1234);
    PCF = 32'hFFFF_FFFC;
    #1;
    n_tests++; if (MispredictE !== 1'b0 || RedirectPCE !== 32'h0) begin
      n_fail++; $display("FAIL nt_wrap: got %0b/%0h want 0/0", MispredictE, RedirectPCE); end
    n_tests++; if (PredTargetF !== 32'h0) begin
      n_fail++; $display("FAIL pcf_wrap: got %0h want 0", PredTargetF); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    bit          e_taken;
    logic [31:0] e_tgt;
    bit          e_misp;
    logic [31:0] e_redir;
    for (int i = 0; i < 8; i++) begin
      pool[i] = (((i % 2 == 0) ? 32'h0 : 32'h5) << (IDX_W + 2)) | ((i / 2) << 2);
    end
    pool[7] = pool[0] | 32'h0010_0000;  // differs only above the tag field
    do_reset();
    for (int c = 0; c < 500; c++) begin
      PCF = pool[$urandom_range(0, 7)];
      drive_e($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0,
              pool[$urandom_range(0, 7)], 32'h1000 + 4 * $urandom_range(0, 3), 1'b0, 32'h0);
      if ($urandom_range(0, 3) != 0) begin
        PredTakenE  = m_taken(PCE);
        PredTargetE = m_target(PCE);
      end else begin
        PredTakenE  = $urandom_range(0, 1) != 0;
        PredTargetE = 32'h1000 + 4 * $urandom_range(0, 3);
      end
      #2;
      e_taken = m_taken(PCF);
      e_tgt   = m_target(PCF);
      e_misp  = m_misp();
      e_redir = TakenE ? PCTargetE : PCE + 32'd4;
      n_tests++; if (PredTakenF !== e_taken) begin
        n_fail++; $display("FAIL rnd_taken c=%0d: got %0b want %0b", c, PredTakenF, e_taken); end
      n_tests++; if (PredTargetF !== e_tgt) begin
        n_fail++; $display("FAIL rnd_target c=%0d: got %0h want %0h", c, PredTargetF, e_tgt); end
      n_tests++; if (MispredictE !== e_misp) begin
        n_fail++; $display("FAIL rnd_misp c=%0d: got %0b want %0b", c, MispredictE, e_misp); end
      n_tests++; if (RedirectPCE !== e_redir) begin
        n_fail++; $display("FAIL rnd_redir c=%0d: got %0h want %0h", c, RedirectPCE, e_redir); end
      tick();
    end
`ifdef BP_PERF_CNT_EN
    n_tests++; if (BrCount !== m_br || MissCount !== m_miss) begin
      n_fail++; $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", BrCount, MissCount, m_br,
                         m_miss);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    PCF   = 32'h0;
    idle_e();
    #1;
    test_reset();
    test_same_cycle_train();
    test_hysteresis();
    test_alias();
    test_target_and_gating();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
